// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM port arbiter slice.
package sdram_arb_pkg;
   localparam int ADDR_W_DEF = 24;
   localparam int DATA_W_DEF = 32;
   localparam int LINE_W_DEF = 256;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_BUSY    = 2'b01,
      S_RELEASE = 2'b10
   } state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_t;
endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin pick; req bit index equals the port id.
module arb_rr2
   import sdram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_t      last,
   output port_t      gnt,
   output logic       valid
);

   always_comb begin
      gnt   = PORT_I;
      valid = |req;
      if (req == 2'b11) begin
         gnt = (last == PORT_I) ? PORT_D : PORT_I;
      end else if (req[1]) begin
         gnt = PORT_D;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the I-cache and D-cache ports onto one SDRAM controller, with an ack watchdog.
// state     | meaning
// S_IDLE    | waiting for a request while the controller is not busy
// S_BUSY    | request forwarded, waiting for sdc_ack
// S_RELEASE | winner's ack is high this cycle
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int LINE_W      = LINE_W_DEF,
   parameter int ACK_TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_start,
   output logic [LINE_W-1:0] i_q,
   output logic              i_ack,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_data,
   input  logic              d_we,
   input  logic              d_start,
   output logic [LINE_W-1:0] d_q,
   output logic              d_ack,
   output logic [ADDR_W-1:0] sdc_addr,
   output logic [DATA_W-1:0] sdc_data,
   output logic              sdc_we,
   output logic              sdc_start,
   input  logic [LINE_W-1:0] sdc_q,
   input  logic              sdc_ack,
   input  logic              sdc_busy,
   output logic              timeout
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   state_t            state, state_nxt;
   port_t             grant, last_grant, arb_gnt;
   logic              arb_valid;
   logic              do_grant, do_done;
   logic [CNT_W-1:0]  wd_cnt;

   arb_rr2 u_rr (
      .req   ({d_start, i_start}),
      .last  (last_grant),
      .gnt   (arb_gnt),
      .valid (arb_valid)
   );

   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      do_done   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!sdc_busy && arb_valid) begin
               do_grant  = 1'b1;
               state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (sdc_ack) begin
               do_done   = 1'b1;
               state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         grant      <= PORT_I;
         last_grant <= PORT_I;
         sdc_addr   <= '0;
         sdc_data   <= '0;
         sdc_we     <= 1'b0;
         sdc_start  <= 1'b0;
         i_q        <= '0;
         d_q        <= '0;
         i_ack      <= 1'b0;
         d_ack      <= 1'b0;
         wd_cnt     <= '0;
         timeout    <= 1'b0;
      end else begin
         state <= state_nxt;
         i_ack <= 1'b0;
         d_ack <= 1'b0;

         if (do_grant) begin
            sdc_start  <= 1'b1;
            grant      <= arb_gnt;
            last_grant <= arb_gnt;
            if (arb_gnt == PORT_D) begin
               sdc_addr <= d_addr;
               sdc_data <= d_data;
               sdc_we   <= d_we;
            end else begin
               sdc_addr <= i_addr;
               sdc_we   <= 1'b0;
            end
         end

         if (do_done) begin
            sdc_start <= 1'b0;
            if (grant == PORT_D) begin
               d_ack <= 1'b1;
               if (!sdc_we) d_q <= sdc_q;
            end else begin
               i_ack <= 1'b1;
               i_q   <= sdc_q;
            end
         end

         // Watchdog only flags; the transfer is still allowed to finish late.
         if (state == S_BUSY && !sdc_ack) begin
            if (wd_cnt != CNT_W'(ACK_TIMEOUT)) wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt >= CNT_W'(ACK_TIMEOUT - 1)) timeout <= 1'b1;
         end else if (state != S_BUSY) begin
            wd_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: transaction-level model of round-robin grants, line returns and watchdog.
module tb_sdram_port_arbiter;
   localparam int AW = 24;
   localparam int DW = 32;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] i_addr, d_addr, sdc_addr;
   logic          i_start, d_start, d_we;
   logic [DW-1:0] d_data, sdc_data;
   logic [LW-1:0] i_q, d_q, sdc_q;
   logic          i_ack, d_ack, sdc_we, sdc_start, sdc_ack, sdc_busy, timeout;

   int checks = 0;
   int errors = 0;

   // controller model knobs
   int            ctl_lat  = 0;
   bit            ctl_en   = 1'b1;
   logic [LW-1:0] ctl_line = '0;
   int            busy_cnt = 0;

   // reference model state
   bit            m_last;
   logic [LW-1:0] exp_i_q, exp_d_q;
   logic [DW-1:0] m_sdc_data;
   bit            grant_log[$];

   sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_W(LW), .ACK_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .i_addr(i_addr), .i_start(i_start), .i_q(i_q), .i_ack(i_ack),
      .d_addr(d_addr), .d_data(d_data), .d_we(d_we), .d_start(d_start),
      .d_q(d_q), .d_ack(d_ack),
      .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we), .sdc_start(sdc_start),
      .sdc_q(sdc_q), .sdc_ack(sdc_ack), .sdc_busy(sdc_busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      sdc_ack = 1'b0;
      sdc_q   = '0;
      forever begin
         @(negedge clk);
         if (sdc_ack) begin
            sdc_ack = 1'b0;
         end else if (sdc_start && ctl_en) begin
            if (busy_cnt >= ctl_lat) begin
               sdc_ack  = 1'b1;
               sdc_q    = ctl_line;
               busy_cnt = 0;
            end else begin
               busy_cnt++;
            end
         end else begin
            busy_cnt = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: simulation still running, required finish");
      $fatal(1, "time limit");
   end

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic model_reset();
      m_last     = 1'b0;
      exp_i_q    = '0;
      exp_d_q    = '0;
      m_sdc_data = '0;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      i_start = 1'b0;
      d_start = 1'b0;
      sdc_busy = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic wait_ack(input int budget, output bit got_i, output bit got_d, output bit expired);
      got_i = 0; got_d = 0; expired = 1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (i_ack || d_ack) begin
            got_i = i_ack; got_d = d_ack; expired = 0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      i_addr = '0; d_addr = '0; d_data = '0; d_we = 1'b0;
      do_reset();
      checks++;
      if ({sdc_start, sdc_we, sdc_addr, sdc_data, i_ack, d_ack, timeout} !== '0)
         begin errors++; $display("FAIL reset_ctrl: start=%b we=%b addr=%h data=%h iack=%b dack=%b to=%b required all 0",
            sdc_start, sdc_we, sdc_addr, sdc_data, i_ack, d_ack, timeout); end
      checks++;
      if (i_q !== '0 || d_q !== '0)
         begin errors++; $display("FAIL reset_q: i_q=%h d_q=%h required 0", i_q, d_q); end
   endtask

   task automatic test_single_read();
      bit gi, gd, ex;
      ctl_lat = 10; ctl_en = 1'b1; ctl_line = {8{32'hA5A5A5A5}};
      i_addr = 24'h000120; i_start = 1'b1;
      @(negedge clk);
      checks++;
      if (sdc_start !== 1'b1 || sdc_addr !== 24'h000120 || sdc_we !== 1'b0)
         begin errors++; $display("FAIL read_issue: start=%b addr=%h we=%b required 1 000120 0", sdc_start, sdc_addr, sdc_we); end
      wait_ack(40, gi, gd, ex);
      i_start = 1'b0;
      checks++;
      if (ex || !gi || gd)
         begin errors++; $display("FAIL read_ack: expired=%b i_ack=%b d_ack=%b required 0 1 0", ex, gi, gd); end
      checks++;
      if (i_q !== ctl_line)
         begin errors++; $display("FAIL read_line: i_q=%h required %h", i_q, ctl_line); end
      @(negedge clk);
      checks++;
      if (i_ack !== 1'b0 || d_ack !== 1'b0)
         begin errors++; $display("FAIL read_ack_width: i_ack=%b d_ack=%b required 0 0", i_ack, d_ack); end
      exp_i_q = ctl_line; m_last = 1'b0;
   endtask

   task automatic test_single_write();
      bit gi, gd, ex;
      ctl_lat = 3; ctl_line = rand_line();
      d_addr = 24'h3FFFFF; d_data = 32'hDEADBEEF; d_we = 1'b1; d_start = 1'b1;
      @(negedge clk);
      checks++;
      if (sdc_start !== 1'b1 || sdc_addr !== 24'h3FFFFF || sdc_data !== 32'hDEADBEEF || sdc_we !== 1'b1)
         begin errors++; $display("FAIL write_issue: start=%b addr=%h data=%h we=%b required 1 3fffff deadbeef 1",
            sdc_start, sdc_addr, sdc_data, sdc_we); end
      wait_ack(40, gi, gd, ex);
      d_start = 1'b0;
      checks++;
      if (ex || gi || !gd)
         begin errors++; $display("FAIL write_ack: expired=%b i_ack=%b d_ack=%b required 0 0 1", ex, gi, gd); end
      checks++;
      if (d_q !== exp_d_q || i_q !== exp_i_q)
         begin errors++; $display("FAIL write_q_hold: d_q=%h i_q=%h required %h %h", d_q, i_q, exp_d_q, exp_i_q); end
      @(negedge clk);
      checks++;
      if (d_ack !== 1'b0)
         begin errors++; $display("FAIL write_ack_width: d_ack=%b required 0", d_ack); end
      m_last = 1'b1; m_sdc_data = 32'hDEADBEEF;
   endtask

   // Each round starts at a negedge with the arbiter idle; random requests, round-robin predicted by rule.
   task automatic run_rounds(input int n, input bit force_both);
      bit gi, gd, ex, w, e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      for (int r = 0; r < n; r++) begin
         if (!i_start && (force_both || $urandom_range(0, 1) == 1)) begin
            i_addr = AW'($urandom); i_start = 1'b1;
         end
         if (!d_start && (force_both || $urandom_range(0, 1) == 1)) begin
            d_addr = AW'($urandom); d_data = $urandom; d_we = 1'($urandom); d_start = 1'b1;
         end
         if (!i_start && !d_start) begin
            i_addr = AW'($urandom); i_start = 1'b1;
         end
         w      = (i_start && d_start) ? !m_last : d_start;
         e_addr = w ? d_addr : i_addr;
         e_we   = w ? d_we : 1'b0;
         e_data = w ? d_data : m_sdc_data;
         ctl_lat = $urandom_range(0, 6); ctl_line = rand_line();
         @(negedge clk);
         checks++;
         if ({sdc_start, sdc_addr, sdc_we, sdc_data} !== {1'b1, e_addr, e_we, e_data})
            begin errors++; $display("FAIL rr_issue round %0d: start=%b addr=%h we=%b data=%h required 1 %h %b %h",
               r, sdc_start, sdc_addr, sdc_we, sdc_data, e_addr, e_we, e_data); end
         m_last = w; m_sdc_data = e_data; grant_log.push_back(w);
         if ($urandom_range(0, 1) == 1) begin
            if (w) begin d_addr = AW'($urandom); d_data = $urandom; d_we = !d_we; end
            else   i_addr = AW'($urandom);
         end
         wait_ack(30, gi, gd, ex);
         if (w) d_start = 1'b0; else i_start = 1'b0;
         checks++;
         if (ex || gi !== !w || gd !== w)
            begin errors++; $display("FAIL rr_ack round %0d: expired=%b i_ack=%b d_ack=%b winner=%0d", r, ex, gi, gd, w); end
         if (!e_we) begin
            if (w) exp_d_q = ctl_line; else exp_i_q = ctl_line;
         end
         checks++;
         if (i_q !== exp_i_q || d_q !== exp_d_q || sdc_addr !== e_addr)
            begin errors++; $display("FAIL rr_data round %0d: i_q=%h d_q=%h addr=%h required %h %h %h",
               r, i_q, d_q, sdc_addr, exp_i_q, exp_d_q, e_addr); end
         @(negedge clk);
         checks++;
         if (i_ack !== 1'b0 || d_ack !== 1'b0)
            begin errors++; $display("FAIL rr_ack_width round %0d: i_ack=%b d_ack=%b required 0 0", r, i_ack, d_ack); end
      end
      i_start = 1'b0; d_start = 1'b0;
   endtask

   task automatic test_contention();
      bit exp_seq[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      do_reset();
      grant_log.delete();
      run_rounds(4, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (k >= grant_log.size() || grant_log[k] !== exp_seq[k])
            begin errors++; $display("FAIL contention_order[%0d]: got %0d required %0d", k,
               (k < grant_log.size()) ? int'(grant_log[k]) : -1, exp_seq[k]); end
      end
   endtask

   task automatic test_random();
      run_rounds(40, 1'b0);
   endtask

   task automatic test_busy();
      bit gi, gd, ex;
      int bad = 0;
      sdc_busy = 1'b1;
      ctl_lat = 2; ctl_line = rand_line();
      d_addr = AW'($urandom); d_data = $urandom; d_we = 1'b0; d_start = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (sdc_start !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0)
         begin errors++; $display("FAIL busy_hold: sdc_start high in %0d cycles, required 0", bad); end
      sdc_busy = 1'b0;
      @(negedge clk);
      checks++;
      if (sdc_start !== 1'b1 || sdc_addr !== d_addr)
         begin errors++; $display("FAIL busy_release: start=%b addr=%h required 1 %h", sdc_start, sdc_addr, d_addr); end
      sdc_busy = 1'b1;
      wait_ack(30, gi, gd, ex);
      d_start = 1'b0; sdc_busy = 1'b0;
      checks++;
      if (ex || gi || !gd || d_q !== ctl_line)
         begin errors++; $display("FAIL busy_complete: expired=%b i_ack=%b d_ack=%b d_q=%h required 0 0 1 %h",
            ex, gi, gd, d_q, ctl_line); end
      exp_d_q = ctl_line; m_last = 1'b1; m_sdc_data = d_data;
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      ctl_lat = 30;
      i_addr = AW'($urandom); i_start = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (sdc_start !== 1'b1)
         begin errors++; $display("FAIL abort_busy: sdc_start=%b required 1", sdc_start); end
      reset = 1'b1; i_start = 1'b0;
      @(negedge clk);
      checks++;
      if ({sdc_start, i_ack, d_ack, sdc_we, sdc_addr, timeout} !== '0 || i_q !== '0 || d_q !== '0)
         begin errors++; $display("FAIL abort_state: start=%b iack=%b dack=%b addr=%h i_q=%h d_q=%h required all 0",
            sdc_start, i_ack, d_ack, sdc_addr, i_q, d_q); end
      reset = 1'b0;
      model_reset();
      run_rounds(3, 1'b0);
   endtask

   task automatic test_watchdog();
      bit gi, gd, ex;
      int k = 0;
      int bad = 0;
      ctl_en = 1'b0;
      i_addr = AW'($urandom); i_start = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (sdc_start) k++;
         checks++;
         if (timeout !== (k >= 17))
            begin errors++; bad++; $display("FAIL watchdog_rise: busy sample %0d timeout=%b required %b", k, timeout, k >= 17); end
      end
      ctl_lat = 0; ctl_line = rand_line(); ctl_en = 1'b1;
      wait_ack(10, gi, gd, ex);
      i_start = 1'b0;
      checks++;
      if (ex || !gi || i_q !== ctl_line)
         begin errors++; $display("FAIL watchdog_late_ack: expired=%b i_ack=%b i_q=%h required 0 1 %h", ex, gi, i_q, ctl_line); end
      repeat (3) @(negedge clk);
      checks++;
      if (timeout !== 1'b1)
         begin errors++; $display("FAIL watchdog_sticky: timeout=%b required 1", timeout); end
      do_reset();
      checks++;
      if (timeout !== 1'b0)
         begin errors++; $display("FAIL watchdog_clear: timeout=%b required 0", timeout); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_single_write();
      test_contention();
      test_random();
      test_busy();
      test_reset_abort();
      test_watchdog();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Shares the single SDRAM controller between the L1 instruction cache (read-only port I) and the L1 data cache (read/write port D). It accepts level-held requests and grants one at a time using round-robin on contention. It forwards the granted request to the controller and returns the 256-bit burst line to the winner with a one-cycle ack. It sits between the two L1 caches and the SDRAM controller, and adds a watchdog on the controller's ack.

Parameters:
ADDR_W, 24, SDRAM word address width.
DATA_W, 32, write data width.
LINE_W, 256, read line width (burst of 8 × 32).
ACK_TIMEOUT, 4096, cycles in S_BUSY without sdc_ack before timeout is flagged.

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
i_addr  in  ADDR_W  port I address
i_start  in  1  port I request (level, held until i_ack)
i_q  out  LINE_W  port I read line
i_ack  out  1  port I completion, one-cycle pulse
d_addr  in  ADDR_W  port D address
d_data  in  DATA_W  port D write data
d_we  in  1  port D write enable (1 = write, 0 = read)
d_start  in  1  port D request (level, held until d_ack)
d_q  out  LINE_W  port D read line
d_ack  out  1  port D completion, one-cycle pulse
sdc_addr  out  ADDR_W  to controller
sdc_data  out  DATA_W  to controller
sdc_we  out  1  to controller
sdc_start  out  1  to controller
sdc_q  in  LINE_W  from controller
sdc_ack  in  1  from controller, one-cycle pulse
sdc_busy  in  1  controller busy (init/refresh/transfer)
timeout  out  1  sticky: ACK_TIMEOUT exceeded

Behaviour:
- Clocking/reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: all outputs 0; state = S_IDLE; last_grant = I, so D wins the first tie; timeout counter = 0.
- States: S_IDLE, S_BUSY, S_RELEASE. Encoding is 2 bits.
- S_IDLE:
  - If sdc_busy = 1 or no start is asserted, stay in S_IDLE.
  - Otherwise pick the winner:
    - only one start asserted → that port wins;
    - both asserted → the port not equal to last_grant wins.
  - Register the winner's addr into sdc_addr.
  - For D: register d_data and d_we into sdc_data and sdc_we.
  - For I: sdc_we = 0; sdc_data holds its previous value.
  - Set sdc_start <= 1, grant <= winner, last_grant <= winner, go to S_BUSY.
  - Latency: sdc_start is high one cycle after the request is sampled.
- S_BUSY:
  - sdc_start and sdc_addr/data/we stay stable until sdc_ack.
  - On sdc_ack = 1:
    - sdc_start <= 0;
    - if the transfer was a read, the granted port's q <= sdc_q;
    - the granted port's ack <= 1;
    - go to S_RELEASE.
  - The timeout counter increments every cycle without ack and saturates. When it reaches ACK_TIMEOUT, timeout <= 1. Timeout is cleared only by reset, and the arbiter keeps waiting.
- S_RELEASE:
  - The ack is high for exactly this cycle; next cycle ack = 0 and state = S_IDLE.
  - The requester drops start at the edge on which it samples ack = 1, so the next S_IDLE evaluation cannot re-grant a stale request.
  - The timeout counter clears.
- Write transactions: d_q is unchanged; d_ack is still pulsed.
- i_q/d_q hold their last read line until that port's next read completes.
- Requester dropping start while granted: ignored. The transfer completes and ack is still pulsed.
- Input changes: addr/data/we changes while granted are ignored, because the values were latched at grant.
- Non-granted port holding start: it waits, never acked. It is guaranteed the next grant, since round-robin bounds the wait to one transaction.
- sdc_ack outside S_BUSY: ignored.
- sdc_busy rising during S_BUSY: no effect.
- Reset mid-transaction: the S_IDLE/zero-output state is taken next cycle, no ack is pulsed, and the requester must re-issue. The controller shares the same reset.

Decomposition:
- Package sdram_arb_pkg:
  - state encoding S_IDLE / S_BUSY / S_RELEASE;
  - port IDs PORT_I = 0, PORT_D = 1;
  - default ADDR_W / DATA_W / LINE_W constants.
- Sub-module arb_rr2: combinational 2-way round-robin grant (req[1:0], last → gnt, valid), so it can be reused for a later third requester. All state stays in sdram_port_arbiter.

Test Plan:
- Single read on I:
  - Stimulus: i_addr = 24'h000120, i_start = 1; model acks after 10 cycles with sdc_q = 256'hA5..A5.
  - Required: sdc_start high 1 cycle after request, sdc_we = 0, i_q = A5..A5, i_ack exactly 1 cycle, d_ack never asserted.
- Single write on D:
  - Stimulus: d_addr = 24'h3FFFFF, d_data = 32'hDEADBEEF, d_we = 1.
  - Required: sdc_addr/sdc_data/sdc_we match, d_ack 1 cycle, d_q unchanged.
- Contention:
  - Stimulus: i_start and d_start asserted in the same cycle after reset, both held.
  - Required: D granted first, then I; on a repeated tie, D and I alternate.
- sdc_busy:
  - Stimulus: sdc_busy = 1 for 50 cycles while d_start = 1.
  - Required: sdc_start stays 0; sdc_start = 1 the cycle after busy drops.
- Reset abort:
  - Stimulus: reset asserted during S_BUSY.
  - Required: next cycle sdc_start = 0, acks = 0, q = 0; a new request is served normally afterwards.
- Watchdog:
  - Stimulus: model never acks, ACK_TIMEOUT = 16.
  - Required: timeout rises after 16 cycles in S_BUSY and stays high until reset; a late ack still completes the transfer.
